// File: rtl/value_settle_monitor.sv
// Watches a free-running register and reports PASS once it has held EXPECT for
// SETTLE consecutive valid samples, or FAIL after TIMEOUT armed cycles.
module value_settle_monitor #(
    parameter int unsigned      WIDTH   = 4,
    parameter logic [WIDTH-1:0] EXPECT  = WIDTH'(4'h5),
    parameter int unsigned      SETTLE  = 2,
    parameter int unsigned      TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             value_vld,
    input  logic [WIDTH-1:0] value,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [7:0]       mismatch_cnt,
    output logic [WIDTH-1:0] first_bad,
    output logic             bad_seen
);

    localparam int unsigned RUN_W = 4;
    localparam int unsigned CYC_W = 8;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_PASS  = 2'd2,
        S_FAIL  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]   mis_q, mis_d;
    logic [WIDTH-1:0]   first_bad_q, first_bad_d;
    logic               bad_seen_q, bad_seen_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;

    logic               sample_ok;
    logic               sample_bad;
    logic [RUN_W-1:0]   run_inc;
    logic [CYC_W-1:0]   cyc_inc;
    logic               settle_hit;
    logic               timeout_hit;

    // X/Z bits never count as a match, so a read-before-write shows up as bad.
    assign sample_ok   = value_vld && !$isunknown(value) && (value == EXPECT);
    assign sample_bad  = value_vld && !sample_ok;
    assign run_inc     = run_q + RUN_W'(1);
    assign cyc_inc     = cyc_q + CYC_W'(1);
    assign settle_hit  = sample_ok && (run_inc == RUN_W'(SETTLE));
    assign timeout_hit = (cyc_inc == CYC_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = S_ARMED;
        end else if (state_q == S_ARMED) begin
            if (settle_hit) begin
                state_d = S_PASS;
            end else if (timeout_hit) begin
                state_d = S_FAIL;
            end
        end
    end

    // Datapath and flag next values; PASS/FAIL leave everything frozen.
    always_comb begin
        run_d       = run_q;
        cyc_d       = cyc_q;
        mis_d       = mis_q;
        first_bad_d = first_bad_q;
        bad_seen_d  = bad_seen_q;
        if (start || (state_q == S_IDLE)) begin
            run_d       = '0;
            cyc_d       = '0;
            mis_d       = '0;
            first_bad_d = '0;
            bad_seen_d  = 1'b0;
        end else if (state_q == S_ARMED) begin
            cyc_d = cyc_inc;
            if (sample_ok) begin
                run_d = run_inc;
            end else if (sample_bad) begin
                run_d = '0;
                if (mis_q != {CNT_W{1'b1}}) begin
                    mis_d = mis_q + CNT_W'(1);
                end
                if (!bad_seen_q) begin
                    first_bad_d = value;
                    bad_seen_d  = 1'b1;
                end
            end
        end
        pass_d = (state_d == S_PASS);
        fail_d = (state_d == S_FAIL);
        done_d = pass_d || fail_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q       <= '0;
            cyc_q       <= '0;
            mis_q       <= '0;
            first_bad_q <= '0;
            bad_seen_q  <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            run_q       <= run_d;
            cyc_q       <= cyc_d;
            mis_q       <= mis_d;
            first_bad_q <= first_bad_d;
            bad_seen_q  <= bad_seen_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
        end
    end

    assign done         = done_q;
    assign pass         = pass_q;
    assign fail         = fail_q;
    assign mismatch_cnt = mis_q;
    assign first_bad    = first_bad_q;
    assign bad_seen     = bad_seen_q;

endmodule

// File: tb/tb_value_settle_monitor.sv
// Bench for value_settle_monitor: vector table, directed corner sequences and
// random stimulus checked against a sample-history reference model.
module tb_value_settle_monitor;

    localparam int unsigned WIDTH   = 4;
    localparam logic [3:0]  EXPECT  = 4'h5;
    localparam int          SETTLE  = 2;
    localparam int          TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       value_vld;
    logic [3:0] value;
    logic       done, pass, fail, bad_seen;
    logic [7:0] mismatch_cnt;
    logic [3:0] first_bad;

    int total = 0;
    int bad   = 0;

    logic [3:0] xv;

    value_settle_monitor #(
        .WIDTH(WIDTH), .EXPECT(EXPECT), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .value_vld(value_vld),
        .value(value), .done(done), .pass(pass), .fail(fail),
        .mismatch_cnt(mismatch_cnt), .first_bad(first_bad), .bad_seen(bad_seen)
    );

    always #5 clk = ~clk;

    // Reference: result plus the list of samples seen since the last arm.
    int         m_res;       // 0 idle, 1 armed, 2 pass, 3 fail
    logic [3:0] h_val[$];
    bit         h_vld[$];
    bit         h_bad[$];

    function automatic bit is_bad(logic [3:0] v);
        return $isunknown(v) || (v !== EXPECT);
    endfunction

    function automatic int trailing_run();
        int n = 0;
        for (int i = h_val.size() - 1; i >= 0; i--) begin
            if (h_vld[i]) begin
                if (h_bad[i]) break;
                n++;
            end
        end
        return n;
    endfunction

    function automatic int exp_mis();
        int n = 0;
        foreach (h_bad[i]) if (h_vld[i] && h_bad[i]) n++;
        return (n > 255) ? 255 : n;
    endfunction

    function automatic logic [3:0] exp_first();
        foreach (h_bad[i]) if (h_vld[i] && h_bad[i]) return h_val[i];
        return 4'h0;
    endfunction

    function automatic bit exp_seen();
        foreach (h_bad[i]) if (h_vld[i] && h_bad[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        if (!rst_n || start || m_res == 0) begin
            h_val.delete(); h_vld.delete(); h_bad.delete();
            m_res = !rst_n ? 0 : (start ? 1 : 0);
        end else if (m_res == 1) begin
            h_val.push_back(value);
            h_vld.push_back(value_vld);
            h_bad.push_back(is_bad(value));
            if (trailing_run() >= SETTLE) m_res = 2;
            else if (h_val.size() >= TIMEOUT) m_res = 3;
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // Apply one cycle of inputs, step the model at the edge, compare after it.
    task automatic cycle(bit r, bit s, bit v, logic [3:0] d);
        rst_n = r; start = s; value_vld = v; value = d;
        @(posedge clk);
        model_step();
        #1;
        chk("m_pass", 32'(pass), 32'(m_res == 2));
        chk("m_fail", 32'(fail), 32'(m_res == 3));
        chk("m_done", 32'(done), 32'(m_res >= 2));
        chk("m_mis", 32'(mismatch_cnt), 32'(exp_mis()));
        chk("m_first", 32'(first_bad), 32'(exp_first()));
        chk("m_seen", 32'(bad_seen), 32'(exp_seen()));
    endtask

    typedef struct {
        bit         r, s, v;
        logic [3:0] d;
        bit         e_done, e_pass, e_fail, e_seen;
        int         e_mis;
    } vec_t;

    function automatic vec_t mkv(bit r, bit s, bit v, logic [3:0] d,
                                 bit ed, bit ep, bit ef, int em, bit es);
        vec_t t;
        t.r = r; t.s = s; t.v = v; t.d = d;
        t.e_done = ed; t.e_pass = ep; t.e_fail = ef; t.e_mis = em; t.e_seen = es;
        return t;
    endfunction

    vec_t vt[11];
    int   mprob;

    initial begin
        xv = 4'bxxxx;
        m_res = 0;
        rst_n = 1'b0; start = 1'b1; value_vld = 1'b1; value = 4'h5;

        vt[0]  = mkv(0, 1, 1, 4'h5, 0, 0, 0, 0, 0);
        vt[1]  = mkv(0, 1, 1, 4'h5, 0, 0, 0, 0, 0);
        vt[2]  = mkv(1, 1, 1, 4'h5, 0, 0, 0, 0, 0);
        vt[3]  = mkv(1, 0, 1, 4'h5, 0, 0, 0, 0, 0);
        vt[4]  = mkv(1, 0, 1, 4'h5, 1, 1, 0, 0, 0);
        vt[5]  = mkv(1, 0, 1, 4'h7, 1, 1, 0, 0, 0);
        vt[6]  = mkv(1, 1, 0, 4'h0, 0, 0, 0, 0, 0);
        vt[7]  = mkv(1, 0, 1, 4'h9, 0, 0, 0, 1, 1);
        vt[8]  = mkv(1, 0, 0, 4'h5, 0, 0, 0, 1, 1);
        vt[9]  = mkv(1, 0, 1, 4'h5, 0, 0, 0, 1, 1);
        vt[10] = mkv(1, 0, 1, 4'h5, 1, 1, 0, 1, 1);

        for (int i = 0; i < 11; i++) begin
            cycle(vt[i].r, vt[i].s, vt[i].v, vt[i].d);
            chk($sformatf("v%0d_done", i), 32'(done), 32'(vt[i].e_done));
            chk($sformatf("v%0d_pass", i), 32'(pass), 32'(vt[i].e_pass));
            chk($sformatf("v%0d_fail", i), 32'(fail), 32'(vt[i].e_fail));
            chk($sformatf("v%0d_mis", i), 32'(mismatch_cnt), 32'(vt[i].e_mis));
            chk($sformatf("v%0d_seen", i), 32'(bad_seen), 32'(vt[i].e_seen));
        end

        // Three unknown samples, then two matches: pass at start+5.
        cycle(1, 1, 0, 4'h0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, xv);
        cycle(1, 0, 1, 4'h5);
        chk("x_pass_early", 32'(pass), 32'(0));
        cycle(1, 0, 1, 4'h5);
        chk("x_pass", 32'(pass), 32'(1));
        chk("x_mis", 32'(mismatch_cnt), 32'(3));
        chk("x_first", 32'(first_bad), 32'(xv));
        chk("x_seen", 32'(bad_seen), 32'(1));

        // Alternating 5/4 never settles: fail at start+16.
        cycle(1, 1, 0, 4'h0);
        for (int i = 1; i <= 16; i++) begin
            cycle(1, 0, 1, (i % 2 == 1) ? 4'h5 : 4'h4);
            if (i == 15) chk("alt_fail_early", 32'(fail), 32'(0));
        end
        chk("alt_fail", 32'(fail), 32'(1));
        chk("alt_done", 32'(done), 32'(1));
        chk("alt_mis", 32'(mismatch_cnt), 32'(8));
        chk("alt_first", 32'(first_bad), 32'(4'h4));

        // Settle lands exactly on the timeout edge: pass wins.
        cycle(1, 1, 0, 4'h0);
        for (int i = 0; i < 14; i++) cycle(1, 0, 0, 4'h5);
        cycle(1, 0, 1, 4'h5);
        chk("co_pass_early", 32'(pass), 32'(0));
        cycle(1, 0, 1, 4'h5);
        chk("co_pass", 32'(pass), 32'(1));
        chk("co_fail", 32'(fail), 32'(0));

        // Re-arm from PASS with a bad value, count, then reset mid-check.
        cycle(1, 1, 1, 4'h3);
        chk("ra_done", 32'(done), 32'(0));
        chk("ra_pass", 32'(pass), 32'(0));
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, 4'h3);
        chk("ra_mis", 32'(mismatch_cnt), 32'(3));
        chk("ra_first", 32'(first_bad), 32'(4'h3));
        cycle(0, 0, 1, 4'h3);
        chk("rst_mis", 32'(mismatch_cnt), 32'(0));
        chk("rst_first", 32'(first_bad), 32'(0));
        chk("rst_seen", 32'(bad_seen), 32'(0));

        // Start coincident with a settling sample discards the sample.
        cycle(1, 1, 0, 4'h0);
        cycle(1, 0, 1, 4'h5);
        cycle(1, 1, 1, 4'h5);
        chk("rs_pass0", 32'(pass), 32'(0));
        cycle(1, 0, 1, 4'h5);
        chk("rs_pass1", 32'(pass), 32'(0));
        cycle(1, 0, 1, 4'h5);
        chk("rs_pass2", 32'(pass), 32'(1));

        // Random traffic with per-block match probability.
        for (int blk = 0; blk < 20; blk++) begin
            mprob = $urandom_range(0, 10);
            for (int i = 0; i < 150; i++) begin
                logic [3:0] d;
                d = ($urandom_range(0, 9) < mprob) ? 4'h5 : 4'($urandom);
                if ($urandom_range(0, 19) == 0) d = xv;
                cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 29) == 0),
                      ($urandom_range(0, 3) != 0), d);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
